// File: rtl/div_mant_seq_pkg.sv
// Shared types and constants for the sequential mantissa divider.
// Build option: DIV_MANT_APPROX_EN (see div_mant_seq).
package div_mant_pkg;

    localparam int MANT_W = 23;
    localparam int SIG_W  = 24;
    localparam int Q_W    = 26;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RND,
        DONE
    } state_t;

    localparam logic [1:0] EXC_NONE   = 2'b00;
    localparam logic [1:0] EXC_DIV0   = 2'b01;
    localparam logic [1:0] EXC_DENORM = 2'b10;

    // Hidden bit is 1 whenever the exponent field is non-zero.
    function automatic logic [SIG_W-1:0] significand(input logic [30:0] operand);
        return {|operand[30:23], operand[22:0]};
    endfunction

endpackage

// File: rtl/div_mant_seq_if.sv
// Operand/result handshake bundle for div_mant_seq.
// master = operand producer / result consumer, slave = the divider.
interface div_mant_seq_if;
    import div_mant_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [30:0]       a_operand;
    logic [30:0]       b_operand;
    logic              out_valid;
    logic              out_ready;
    logic              normalised;
    logic [MANT_W-1:0] quotient_mantissa;
    logic [1:0]        exc;

    modport master (
        output in_valid, a_operand, b_operand, out_ready,
        input  in_ready, out_valid, normalised, quotient_mantissa, exc
    );

    modport slave (
        input  in_valid, a_operand, b_operand, out_ready,
        output in_ready, out_valid, normalised, quotient_mantissa, exc
    );

endinterface

// File: rtl/div_mant_seq_round.sv
// Single-position normalise plus round-half-up of the raw 26-bit quotient.
// The 23-bit sum wraps on carry-out, the same as the mantissa multiplier.
module div_mant_round
    import div_mant_pkg::*;
(
    input  logic [Q_W-1:0]    q,
    output logic              normalised,
    output logic [MANT_W-1:0] mantissa
);

    // Pick the mantissa window from the integer bit, then add the guard bit.
    always_comb begin
        normalised = q[Q_W-1];
        if (q[Q_W-1]) begin
            mantissa = q[24:2] + MANT_W'(q[1]);
        end else begin
            mantissa = q[23:1] + MANT_W'(q[0]);
        end
    end

endmodule

// File: rtl/div_mant_seq.sv
// Iterative restoring mantissa divider, one quotient bit per cycle.
// Build option: DIV_MANT_APPROX_EN limits CALC to APPROX_QBITS quotient bits;
// the default build computes all 26 bits exactly.
module div_mant_seq
    import div_mant_pkg::*;
#(
    parameter int APPROX_QBITS = 14
) (
    input  logic          clk,
    input  logic          rst,
    div_mant_seq_if.slave bus
);

`ifdef DIV_MANT_APPROX_EN
    localparam int ITERS = APPROX_QBITS;
`else
    // APPROX_QBITS has no effect in the exact build.
    localparam int ITERS = Q_W + 0 * APPROX_QBITS;
`endif
    localparam logic [4:0] LAST_CNT = 5'(Q_W - ITERS);

    state_t            state;
    logic [Q_W-1:0]    rem_r;
    logic [Q_W-1:0]    q_r;
    logic [4:0]        cnt;
    logic [SIG_W-1:0]  sb_r;
    logic [1:0]        fast_exc;
    logic              out_valid_r;
    logic              norm_r;
    logic [MANT_W-1:0] mant_r;
    logic [1:0]        exc_r;

    logic [SIG_W-1:0]  sa_in;
    logic [SIG_W-1:0]  sb_in;
    logic [Q_W-1:0]    sb_ext;
    logic              rnd_norm;
    logic [MANT_W-1:0] rnd_mant;

    assign sa_in  = significand(bus.a_operand);
    assign sb_in  = significand(bus.b_operand);
    assign sb_ext = {2'b00, sb_r};

    assign bus.in_ready          = (state == IDLE) && !rst;
    assign bus.out_valid         = out_valid_r;
    assign bus.normalised        = norm_r;
    assign bus.quotient_mantissa = mant_r;
    assign bus.exc               = exc_r;

    div_mant_round u_round (
        .q          (q_r),
        .normalised (rnd_norm),
        .mantissa   (rnd_mant)
    );

    // Control FSM and datapath; exception cases skip CALC and are published
    // from RND so they appear one edge after the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rem_r       <= '0;
            q_r         <= '0;
            cnt         <= '0;
            sb_r        <= '0;
            fast_exc    <= EXC_NONE;
            out_valid_r <= 1'b0;
            norm_r      <= 1'b0;
            mant_r      <= '0;
            exc_r       <= EXC_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sb_r  <= sb_in;
                        rem_r <= {2'b00, sa_in};
                        q_r   <= '0;
                        cnt   <= 5'd25;
                        if (sb_in == '0) begin
                            fast_exc <= EXC_DIV0;
                            state    <= RND;
                        end else if (!sb_in[SIG_W-1]) begin
                            fast_exc <= EXC_DENORM;
                            state    <= RND;
                        end else begin
                            fast_exc <= EXC_NONE;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (rem_r >= sb_ext) begin
                        q_r[cnt] <= 1'b1;
                        rem_r    <= (rem_r - sb_ext) << 1;
                    end else begin
                        rem_r    <= rem_r << 1;
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == LAST_CNT) begin
                        state <= RND;
                    end
                end
                RND: begin
                    out_valid_r <= 1'b1;
                    exc_r       <= fast_exc;
                    case (fast_exc)
                        EXC_DIV0: begin
                            norm_r <= 1'b0;
                            mant_r <= '0;
                        end
                        EXC_DENORM: begin
                            norm_r <= 1'b1;
                            mant_r <= '1;
                        end
                        default: begin
                            norm_r <= rnd_norm;
                            mant_r <= rnd_mant;
                        end
                    endcase
                    state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
